// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam int         DIV_ITERS    = 32;
  localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_ITERS - 1);

  // Magnitude of a possibly-signed operand; 0x80000000 maps to itself as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the decode stage and the mul/div unit.
interface muldiv_unit_if;
  logic        valid_i;
  logic        inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i;
  logic        inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        kill_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;

  modport master (
    output valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
           inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
           operand_a_i, operand_b_i, kill_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, inst_mul_i, inst_mulh_i, inst_mulhsu_i, inst_mulhu_i,
           inst_div_i, inst_divu_i, inst_rem_i, inst_remu_i,
           operand_a_i, operand_b_i, kill_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/muldiv_unit_divider.sv
// Unsigned 32-iteration restoring divider; done_o flags the cycle of the final step.
module muldiv_unit_divider
  import muldiv_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [32:0] shifted, trial;

  // Remainder is always below the divisor, so the shifted value needs 33 bits.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = DIV_CNT_INIT;
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
    end else if (busy_q) begin
      if (trial[32]) begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end else begin
        rem_d = trial[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 5'd1;
    end
    if (kill_i) busy_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: 2-cycle multiplier, iterative divider, sign fix-up and control FSM.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter bit SUPPORT_MUL = 1'b1,
  parameter bit SUPPORT_DIV = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  muldiv_unit_if.slave bus
);

  state_e      state_q, state_d;
  logic [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic        mul_hi_q, mul_hi_d;
  logic        is_rem_q, is_rem_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic        special_q, special_d;
  logic [31:0] fix_res_q, fix_res_d;
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;

  logic        op_mul, op_div, sgn_div, accept, b_zero, ovf;
  logic [31:0] a, b, div_dividend, div_divisor, div_quo, div_rem, fix_val;
  logic        div_start, div_done;
  logic signed [63:0] prod;

  assign a       = bus.operand_a_i;
  assign b       = bus.operand_b_i;
  assign op_mul  = bus.inst_mul_i | bus.inst_mulh_i | bus.inst_mulhsu_i | bus.inst_mulhu_i;
  assign op_div  = bus.inst_div_i | bus.inst_divu_i | bus.inst_rem_i | bus.inst_remu_i;
  assign sgn_div = bus.inst_div_i | bus.inst_rem_i;
  assign accept  = bus.valid_i && (state_q == S_IDLE) && !bus.kill_i;
  assign b_zero  = (b == '0);
  assign ovf     = sgn_div && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign div_dividend = abs32(a, sgn_div);
  assign div_divisor  = abs32(b, sgn_div);

  // Only the low 64 bits of the 66-bit signed product are ever selected.
  assign prod = 64'($signed(mul_a_q)) * 64'($signed(mul_b_q));

  always_comb begin
    fix_val = is_rem_q ? (neg_r_q ? (~div_rem + 32'd1) : div_rem)
                       : (neg_q_q ? (~div_quo + 32'd1) : div_quo);
    if (special_q) fix_val = fix_res_q;
  end

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_hi_d  = mul_hi_q;
    is_rem_d  = is_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    special_d = special_q;
    fix_res_d = fix_res_q;
    valid_d   = 1'b0;
    result_d  = result_q;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && op_mul) begin
          mul_a_d  = {(bus.inst_mulh_i | bus.inst_mulhsu_i) & a[31], a};
          mul_b_d  = {bus.inst_mulh_i & b[31], b};
          mul_hi_d = !bus.inst_mul_i;
          state_d  = S_MUL;
        end else if (accept && op_div) begin
          is_rem_d = bus.inst_rem_i | bus.inst_remu_i;
          neg_q_d  = sgn_div && (a[31] ^ b[31]);
          neg_r_d  = sgn_div && a[31];
          if (!SUPPORT_DIV) begin
            special_d = 1'b1;
            fix_res_d = '0;
            state_d   = S_FIX;
          end else if (b_zero || ovf) begin
            special_d = 1'b1;
            if (bus.inst_rem_i | bus.inst_remu_i) fix_res_d = b_zero ? a : '0;
            else                                  fix_res_d = b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            state_d   = S_FIX;
          end else begin
            special_d = 1'b0;
            div_start = 1'b1;
            state_d   = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = SUPPORT_MUL ? (mul_hi_q ? prod[63:32] : prod[31:0]) : '0;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      S_DIV: if (div_done) state_d = S_FIX;
      S_FIX: begin
        result_d = fix_val;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush drops everything, including a result about to be written.
    if (bus.kill_i) begin
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      result_d  = result_q;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_hi_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      special_q <= 1'b0;
      fix_res_q <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_hi_q  <= mul_hi_d;
      is_rem_q  <= is_rem_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      special_q <= special_d;
      fix_res_q <= fix_res_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  generate
    if (SUPPORT_DIV) begin : g_div
      muldiv_unit_divider u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (div_start),
        .kill_i      (bus.kill_i),
        .dividend_i  (div_dividend),
        .divisor_i   (div_divisor),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
      );
    end else begin : g_no_div
      assign div_done = 1'b1;
      assign div_quo  = '0;
      assign div_rem  = '0;
    end
  endgenerate

  assign bus.ready_o  = (state_q == S_IDLE);
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases, random ops, kill and reset.
module tb_muldiv_unit;

  localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
  localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n;
  int    edge_cnt = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  sb_q[$];
  exp_t  mon_e;

  muldiv_unit_if bus();

  muldiv_unit #(.SUPPORT_MUL(1'b1), .SUPPORT_DIV(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk)
    if (bus.valid_i)
      assert ($onehot0({bus.inst_remu_i, bus.inst_rem_i, bus.inst_divu_i, bus.inst_div_i,
                        bus.inst_mulhu_i, bus.inst_mulhsu_i, bus.inst_mulh_i, bus.inst_mul_i}))
      else $error("more than one op flag high");

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid_o) begin
      if (sb_q.size() == 0) chk("spurious_valid", 32'(bus.valid_o), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        chk(mon_e.tag, bus.result_o, mon_e.res);
        chk({mon_e.tag, "_cyc"}, 32'(edge_cnt), 32'(mon_e.due));
      end
    end
  end

  function automatic logic [31:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = sa * sb;          return p[31:0];  end
      OP_MULH:   begin p = sa * sb;          return p[63:32]; end
      OP_MULHSU: begin p = sa * $signed(ub); return p[63:32]; end
      OP_MULHU:  begin up = ua * ub;         return up[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub;
        return up[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      OP_REMU: begin
        if (b == 0) return a;
        up = ua % ub;
        return up[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < OP_DIV) return 2;
    if (b == 0) return 2;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  task automatic set_op(input logic [7:0] op);
    {bus.inst_remu_i, bus.inst_rem_i, bus.inst_divu_i, bus.inst_div_i,
     bus.inst_mulhu_i, bus.inst_mulhsu_i, bus.inst_mulh_i, bus.inst_mul_i} = op;
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push, input string tag);
    int w = 0;
    @(negedge clk);
    set_op(op);
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    bus.valid_i     = 1'b1;
    while (!bus.ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready_o) chk({tag, "_ready_timeout"}, 32'(bus.ready_o), 32'd1);
    @(posedge clk);
    #1;
    if (push) sb_q.push_back('{exp, edge_cnt + lat - 1, tag});
    bus.valid_i = 1'b0;
    set_op(8'h00);
  endtask

  task automatic run(input string tag, input logic [7:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, exp, lat_of(op, a, b), 1'b1, tag);
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_q", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n0;
    logic [7:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.operand_a_i = '0;
    bus.operand_b_i = '0;
    set_op(8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    chk("rst_valid", 32'(bus.valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);

    run("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu_max",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_neg", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run("mul_b2b",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("div_neg",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run("rem_neg",    OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run("divu_100_7", OP_DIVU,   32'd100,       32'd7,         32'd14);
    run("remu_100_7", OP_REMU,   32'd100,       32'd7,         32'd2);
    run("div_by0",    OP_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    run("remu_by0",   OP_REMU,   32'd5,         32'd0,         32'd5);
    run("div_ovf",    OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",    OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    drain();

    for (int i = 0; i < 24; i++) begin
      op = 8'h01 << $urandom_range(0, 7);
      a  = $urandom();
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom();
      endcase
      run($sformatf("rnd%0d_op%02h", i, op), op, a, b, model(op, a, b));
    end
    drain();

    // Flush a divide mid-flight, then restart immediately with a multiply.
    issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0, "divu_killed");
    n0 = edge_cnt;
    while (edge_cnt != n0 + 9) @(negedge clk);
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1 bus.kill_i = 1'b0;
    run("mul_after_kill", OP_MUL, 32'd3, 32'd5, 32'd15);
    chk("kill_accept_cyc", 32'(edge_cnt), 32'(n0 + 11));
    while (edge_cnt < n0 + 41) @(negedge clk);
    chk("kill_result_hold", bus.result_o, 32'd15);

    // kill together with valid in IDLE must drop the request
    @(negedge clk);
    set_op(OP_MUL);
    bus.valid_i = 1'b1;
    bus.kill_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    set_op(8'h00);
    @(negedge clk);
    chk("kill_drop_ready", 32'(bus.ready_o), 32'd1);
    repeat (4) @(negedge clk);

    // Reset in the middle of a divide
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 1'b0, "div_reset");
    n0 = edge_cnt;
    while (edge_cnt != n0 + 19) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(bus.valid_o), 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_ready", 32'(bus.ready_o), 32'd1);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // valid with no op flag is ignored
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    chk("noop_ready", 32'(bus.ready_o), 32'd1);
    repeat (4) @(negedge clk);
    chk("noop_result", bus.result_o, 32'd0);
    run("mul_final", OP_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
